// File: rtl/pr_timer.sv
// -----------------------------------------------------------------------------
// pr_timer -- programmable interval timer on the processor-side bus.
//
// The bridge decodes the timer window and asserts sel; the timer owns three
// word registers (CTRL, PRESET, COUNT) and a four-state counting FSM
// (IDLE -> LOAD -> CNT -> INT). IRQ feeds one of the CPU HWInt lines.
//
// Ports:
//   clk    in   1   system clock, all state updates on the rising edge
//   reset  in   1   asynchronous active-low reset, clears all state
//   sel    in   1   bridge chip-select for this timer window
//   Addr   in  32   bus address, only Addr[3:2] (word offset) is decoded
//   We     in   1   write strobe, qualified by sel
//   Din    in  32   write data
//   Dout   out 32   read data, combinational from Addr[3:2]
//   IRQ    out  1   interrupt request (CTRL.IM & pending)
//
// Register map (Addr[3:2]):
//   0 CTRL   : [0] Enable, [2:1] Mode (01 auto-reload, else one-shot), [3] IM
//   1 PRESET : reload value
//   2 COUNT  : read-only current count
//   3        : reads 0
// -----------------------------------------------------------------------------
module pr_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [31:0] Addr,
   input  logic        We,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOAD     = 2'd1;
   localparam logic [1:0] ST_CNT      = 2'd2;
   localparam logic [1:0] ST_INT      = 2'd3;

   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_PRESET  = 2'd1;
   localparam logic [1:0] OFF_COUNT   = 2'd2;

   localparam logic [1:0] MODE_RELOAD = 2'b01;

   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic [1:0]  r_state;
   logic        r_pending;

   logic [3:0]  w_ctrl_nxt;
   logic [31:0] w_preset_nxt;
   logic [31:0] w_count_nxt;
   logic [1:0]  w_state_nxt;
   logic        w_pending_nxt;
   logic        w_pend_set;
   logic        w_pend_clr;
   logic        w_wr_ctrl;
   logic        w_wr_preset;
   logic        w_unused_addr;

   assign w_wr_ctrl     = sel & We & (Addr[3:2] == OFF_CTRL);
   assign w_wr_preset   = sel & We & (Addr[3:2] == OFF_PRESET);
   // Only the word offset is decoded; the rest of the address is don't-care.
   assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};

   // Next-state logic: FSM step first, then CPU writes override the fields they touch.
   always_comb begin
      w_ctrl_nxt   = r_ctrl;
      w_preset_nxt = r_preset;
      w_count_nxt  = r_count;
      w_state_nxt  = r_state;
      w_pend_set   = 1'b0;
      w_pend_clr   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_ctrl[0]) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = ST_CNT;
         end
         ST_CNT: begin
            if (!r_ctrl[0]) begin
               // Disabled mid-count: park in IDLE with COUNT frozen.
               w_state_nxt = ST_IDLE;
            end else if (r_count > 32'd1) begin
               w_count_nxt = r_count - 32'd1;
            end else begin
               // COUNT==1 reaches zero now; COUNT==0 (PRESET 0) fires without decrementing.
               w_count_nxt = 32'd0;
               w_state_nxt = ST_INT;
               w_pend_set  = 1'b1;
            end
         end
         ST_INT: begin
            if (r_ctrl[2:1] == MODE_RELOAD) begin
               w_pend_clr  = 1'b1;
               w_state_nxt = ST_LOAD;
            end else begin
               w_ctrl_nxt[0] = 1'b0;
               w_state_nxt   = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // A CPU write to CTRL on the same edge as the one-shot Enable clear wins.
      if (w_wr_ctrl) begin
         w_ctrl_nxt = Din[3:0];
      end else begin
         w_ctrl_nxt = w_ctrl_nxt;
      end

      // PRESET only reaches COUNT at the next LOAD.
      if (w_wr_preset) begin
         w_preset_nxt = Din;
      end else begin
         w_preset_nxt = r_preset;
      end

      // Setting pending takes priority over any clear on the same edge.
      if (w_pend_set) begin
         w_pending_nxt = 1'b1;
      end else if (w_pend_clr | w_wr_ctrl | w_wr_preset) begin
         w_pending_nxt = 1'b0;
      end else begin
         w_pending_nxt = r_pending;
      end
   end

   // Timer state registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl    <= 4'd0;
         r_preset  <= 32'd0;
         r_count   <= 32'd0;
         r_state   <= ST_IDLE;
         r_pending <= 1'b0;
      end else begin
         r_ctrl    <= w_ctrl_nxt;
         r_preset  <= w_preset_nxt;
         r_count   <= w_count_nxt;
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // Zero-latency read mux, independent of sel and We.
   always_comb begin
      case (Addr[3:2])
         OFF_CTRL:   Dout = {28'd0, r_ctrl};
         OFF_PRESET: Dout = r_preset;
         OFF_COUNT:  Dout = r_count;
         default:    Dout = 32'd0;
      endcase
   end

   assign IRQ = r_ctrl[3] & r_pending;

endmodule

// File: doc/pr_timer.md
# pr_timer

Programmable interval timer that answers the CPU's processor-side bus (PrAddr/PrWD/PrWe, read data back on data_from_bridge) as a bridge-selected responder. It raises one of the CPU's HWInt lines. The bridge decodes the timer's address window and drives `sel`; the timer owns three word registers and a four-state counting FSM. Two instances feed HWInt[0] and HWInt[1].

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (reset==0 clears all state immediately).
- sel  in  1  bridge chip-select for this timer's window.
- Addr  in  32  PrAddr; only Addr[3:2] is decoded (word offset).
- We  in  1  PrWe; write strobe, qualified by sel.
- Din  in  32  PrWD write data.
- Dout  out  32  read data to bridge; combinational from Addr[3:2].
- IRQ  out  1  interrupt request to CPU HWInt.

## Operation
- Register map, offset Addr[3:2]:
  - 0 CTRL: [0] Enable, [2:1] Mode, [3] IM; bits [31:4] read 0.
  - 1 PRESET: 32-bit reload value.
  - 2 COUNT: read-only.
  - 3: reads 0.
- Mode 00 is one-shot; Mode 01 is auto-reload; 1x behaves as 00.
- Write: occurs at the edge where sel&&We. Writes to COUNT and offset 3 are ignored. Any write to CTRL or PRESET clears `pending`.
- Read: Dout = selected register regardless of sel and We. Zero latency.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: Enable=1 → LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT, Enable=0: → IDLE; COUNT holds.
  - CNT, COUNT>1: COUNT<=COUNT-1.
  - CNT, COUNT==1: COUNT<=0 → INT; pending<=1.
  - CNT, COUNT==0 (PRESET 0): → INT, no decrement; pending<=1.
  - INT, one-shot: CTRL.Enable<=0 → IDLE; pending stays 1 (sticky).
  - INT, auto-reload: pending<=0 → LOAD.
- IRQ = IM & pending.
- Arithmetic: 32-bit unsigned, no wrap. COUNT never decrements below 0.
- Simultaneous events:
  - CPU CTRL write and the INT Enable-clear on the same edge: CPU value wins.
  - PRESET written during CNT: current COUNT unaffected; the new value applies at the next LOAD.
  - CTRL write with Enable=1 during CNT: FSM continues; Mode/IM update immediately.
  - pending set and CPU clear on the same edge: set wins.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, pending=0, IRQ=0, Dout=0.
- Timeline with PRESET=N≥1, CTRL written with Enable=1 at edge E0:
  - E1: LOAD.
  - E2: COUNT=N, CNT.
  - E(2+N): COUNT=0, INT, IRQ=1 if IM.
- One-shot:
  - E(3+N): IDLE, Enable=0.
  - IRQ stays high until CTRL or PRESET is written; it drops the cycle after that write edge.
- Auto-reload:
  - IRQ is high exactly one cycle (E(2+N)..E(3+N)).
  - COUNT=N again at E(4+N).
  - Period is N+2 cycles.
- Reset asserted mid-count: all state clears asynchronously and IRQ drops without waiting for clk. After release the timer stays idle until Enable is written.

## Test plan
- Reset then read offsets 0/1/2/3 → all 0; IRQ=0. Pulse reset low mid-CNT → IRQ and COUNT go to 0 immediately.
- PRESET=5, CTRL=0x9 (one-shot, IM) → COUNT reads 5,4,3,2,1,0 on consecutive cycles from E2. IRQ rises at E7 and stays high; CTRL reads 0x8 after E8. Write PRESET → IRQ=0 next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM) → IRQ one-cycle pulses every 5 cycles, first at E5. COUNT sequence 3,2,1,0,(LOAD),3…
- CTRL=0x1 (IM=0), PRESET=2 → COUNT reaches 0, IRQ stays 0. Then write CTRL=0x8 → IRQ stays 0 (pending cleared by the write).
- Clear Enable mid-count at COUNT=7 → FSM goes to IDLE, COUNT holds 7. Write PRESET=0, then Enable=1 → INT the cycle after LOAD (PRESET-0 case).
- sel=0 with We=1 writing CTRL → no register changes. Writes to COUNT with sel=1 are ignored.
